// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: prefetching reader that drains a RAM FIFO into a 2-entry output buffer with valid/ready delivery
module fifo_stream_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             res,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_shift_out,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] words_out
);
   logic [1:0]       occ_q, occ_d, occ_p;
   logic             infl_q;
   logic [WIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;
   logic [2:0]       lvl;

   assign out_valid = occ_q != 2'd0;
   assign out_data  = b0_q;
   assign words_out = cnt_q;
   assign pop       = out_valid & out_ready;
   // pop implies occ_q >= 1, so this never underflows; the level counts the in-flight word as already buffered
   assign lvl       = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
   assign fifo_shift_out = !fifo_empty & !flush & !res & (lvl < 3'd2);

   // shift out the head on pop, then land the in-flight word right behind the last valid entry
   always_comb begin
      occ_p = occ_q - {1'b0, pop};
      b0_d  = (infl_q && occ_p == 2'd0) ? fifo_rdata : (pop ? b1_q : b0_q);
      b1_d  = (infl_q && occ_p != 2'd0) ? fifo_rdata : b1_q;
      occ_d = flush ? 2'd0 : occ_p + {1'b0, infl_q};
      cnt_d = flush ? cnt_q : cnt_q + CNT_W'(pop);
   end

   // state registers; a read in flight at reset or flush is simply forgotten
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         occ_q  <= '0;
         infl_q <= 1'b0;
         b0_q   <= '0;
         b1_q   <= '0;
         cnt_q  <= '0;
      end else begin
         occ_q  <= occ_d;
         infl_q <= fifo_shift_out;
         b0_q   <= b0_d;
         b1_q   <= b1_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized bench comparing the reader against a word-queue model of the upstream FIFO and delivery buffer
module tb_fifo_stream_reader;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         res, fifo_empty, flush, out_ready;
   logic [W-1:0] fifo_rdata;
   logic         fifo_shift_out, out_valid, shift4, valid4;
   logic [W-1:0] out_data, data4;
   logic [15:0]  words_out;
   logic [3:0]   words_out4;

   int           n_chk = 0, n_fail = 0;
   logic [W-1:0] src[$];
   logic [W-1:0] mq[$];
   logic         m_infl = 1'b0;
   logic [W-1:0] m_infl_val = '0;
   int           m_cnt = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(.WIDTH(W), .CNT_W(16)) u_dut (
      .clk(clk), .res(res), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_shift_out(fifo_shift_out), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .words_out(words_out));

   fifo_stream_reader #(.WIDTH(W), .CNT_W(4)) u_dut4 (
      .clk(clk), .res(res), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_shift_out(shift4), .flush(flush), .out_valid(valid4),
      .out_ready(out_ready), .out_data(data4), .words_out(words_out4));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: drive inputs, compare against the model, then advance the model across the edge
   task automatic step(input logic rdy, input logic gap, input logic fl);
      logic e_valid, e_pop, e_shift;
      @(negedge clk);
      out_ready  = rdy;
      flush      = fl;
      fifo_empty = gap || src.size() == 0;
      fifo_rdata = m_infl ? m_infl_val : W'($urandom);
      #1;
      e_valid = mq.size() != 0;
      e_pop   = e_valid && rdy;
      e_shift = !fifo_empty && !fl && (mq.size() + int'(m_infl) - int'(e_pop) < 2);
      check("valid", out_valid, e_valid);
      check("valid4", valid4, e_valid);
      if (e_valid) begin
         check("data", out_data, mq[0]);
         check("data4", data4, mq[0]);
      end
      check("shift", fifo_shift_out, e_shift);
      check("shift4", shift4, e_shift);
      check("count", words_out, m_cnt % 65536);
      check("count4", words_out4, m_cnt % 16);
      if (fl) mq.delete();
      else begin
         if (e_pop) begin
            void'(mq.pop_front());
            m_cnt++;
         end
         if (m_infl) mq.push_back(m_infl_val);
      end
      m_infl = e_shift;
      if (e_shift) m_infl_val = src.pop_front();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_count"}, words_out, 0);
      check({tag, "_shift"}, fifo_shift_out, 0);
      check({tag, "_count4"}, words_out4, 0);
   endtask

   // asynchronous reset asserted mid-cycle; any word in flight is lost along with the buffer
   task automatic do_reset();
      res        = 1'b1;
      fifo_empty = 1'b1;
      out_ready  = 1'b0;
      flush      = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      @(negedge clk);
      res = 1'b0;
      mq.delete();
      m_infl = 1'b0;
      m_cnt  = 0;
   endtask

   initial begin
      int pushed, cycles;
      res = 1'b1; fifo_empty = 1'b1; out_ready = 1'b0; flush = 1'b0; fifo_rdata = '0;
      #3;
      check_reset_outputs("rst_init");
      repeat (2) @(posedge clk);
      @(negedge clk);
      res = 1'b0;

      for (int i = 1; i <= 8; i++) src.push_back(W'(i));
      repeat (12) step(1'b1, 1'b0, 1'b0);
      check("burst_count", words_out, 8);
      check("burst_idle", out_valid, 0);

      for (int i = 0; i < 4; i++) src.push_back(W'(8'h10 + i));
      repeat (10) step(1'b0, 1'b0, 1'b0);
      check("stall_head", out_data, 8'h10);
      repeat (8) step(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) src.push_back(W'(8'h20 + i));
      repeat (4) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (10) step(1'b1, 1'b0, 1'b0);

      pushed = 0;
      cycles = 0;
      while ((pushed < 1000 || src.size() != 0) && cycles < 20000) begin
         if (pushed < 1000 && src.size() < 4) begin
            src.push_back(W'($urandom));
            pushed++;
         end
         if (m_infl && $urandom_range(0, 299) == 0) do_reset();
         else step(1'(($urandom)), $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
         cycles++;
      end
      check("random_done", cycles < 20000, 1);
      repeat (6) step(1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) src.push_back(W'(8'h30 + i));
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 13; i++) src.push_back(W'(8'h40 + i));
      repeat (25) step(1'b1, 1'b0, 1'b0);
      check("wrap_count", words_out, 17);
      check("wrap_count4", words_out4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
